// File: rtl/gcd_stein_seq_pkg.sv
// Shared types and sizing helpers for the binary (Stein) GCD engine.
// Optional feature macro used across this slice: GCD_CYCLE_COUNT_EN.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    REDUCE,
    DONE
  } gcd_state_t;

  // Worst-case edges from accept to out_valid rising for magnitude width m.
  function automatic int cycle_bound(input int m);
    return 5 * m + 3;
  endfunction

  // Width of the common power-of-two shift count k.
  function automatic int k_width(input int m);
    return $clog2(m + 1);
  endfunction

  // Width of the optional compute-cycle counter.
  function automatic int cnt_width(input int m);
    return $clog2(5 * m + 4);
  endfunction

endpackage

// File: rtl/gcd_stein_seq_if.sv
// Operand and result valid/ready channels of the GCD engine.
// out_cycles is present only when GCD_CYCLE_COUNT_EN is defined.
interface gcd_stein_seq_if #(
  parameter int WIDTH = 8
);
  import gcd_pkg::*;

  localparam int M = WIDTH - 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;

`ifdef GCD_CYCLE_COUNT_EN
  logic [cnt_width(M)-1:0] out_cycles;

  modport slave (
    input  in_valid, in_p, in_q, out_ready,
    output in_ready, out_valid, out_gcd, out_cycles
  );

  modport master (
    output in_valid, in_p, in_q, out_ready,
    input  in_ready, out_valid, out_gcd, out_cycles
  );
`else
  modport slave (
    input  in_valid, in_p, in_q, out_ready,
    output in_ready, out_valid, out_gcd
  );

  modport master (
    output in_valid, in_p, in_q, out_ready,
    input  in_ready, out_valid, out_gcd
  );
`endif

endinterface

// File: rtl/gcd_stein_seq_step.sv
// One REDUCE step of Stein's algorithm: strip a factor of two from an even
// operand, otherwise subtract the smaller odd operand from the larger.
module gcd_step #(
  parameter int M = 7
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] a_nxt,
  output logic [M-1:0] b_nxt,
  output logic         zero_flag
);

  always_comb begin
    // NOTE: every output gets a default first so no path can leave a latch.
    zero_flag = (a == '0) || (b == '0);
    a_nxt     = a;
    b_nxt     = b;
    if (!zero_flag) begin
      if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a >= b) begin
        a_nxt = a - b;
      end else begin
        b_nxt = b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_stein_seq.sv
// Sequential binary GCD engine with valid/ready operand and result channels.
// Define GCD_CYCLE_COUNT_EN to add the out_cycles compute-cycle counter.
module gcd_stein_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  gcd_stein_seq_if.slave  io
);

  localparam int M  = WIDTH - 1;
  localparam int KW = k_width(M);

  gcd_state_t       state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [M-1:0]     b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_valid_q, out_valid_d;

`ifdef GCD_CYCLE_COUNT_EN
  localparam int CW = cnt_width(M);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_cycles_q, out_cycles_d;
`endif

  logic [M-1:0] step_a, step_b;
  logic         step_zero;
  logic [M-1:0] gcd_mag;
  logic         unused_sign;

  gcd_step #(.M(M)) u_step (
    .a        (a_q),
    .b        (b_q),
    .a_nxt    (step_a),
    .b_nxt    (step_b),
    .zero_flag(step_zero)
  );

  // One operand is zero on entry to DONE, so the OR is the odd part of the GCD.
  assign gcd_mag     = (a_q | b_q) << k_q;
  assign unused_sign = io.in_p[WIDTH-1] ^ io.in_q[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    out_gcd_d   = out_gcd_q;
    out_valid_d = out_valid_q;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_d        = cnt_q;
    out_cycles_d = out_cycles_q;
`endif

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_p[M-1:0];
          b_d     = io.in_q[M-1:0];
          k_d     = '0;
          state_d = NORM;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end

      NORM: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (step_zero) begin
          state_d = DONE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = REDUCE;
        end
      end

      REDUCE: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (step_zero) begin
          state_d = DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end

      DONE: begin
        // First DONE cycle captures the result; it then holds until taken.
        if (!out_valid_q) begin
          out_gcd_d   = {1'b0, gcd_mag};
          out_valid_d = 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
          out_cycles_d = cnt_q;
`endif
        end else if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      out_gcd_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q        <= '0;
      out_cycles_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      out_gcd_q   <= out_gcd_d;
      out_valid_q <= out_valid_d;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q        <= cnt_d;
      out_cycles_q <= out_cycles_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_gcd   = out_gcd_q;
`ifdef GCD_CYCLE_COUNT_EN
  assign io.out_cycles = out_cycles_q;
`endif

endmodule

// File: tb/tb_gcd_stein_seq.sv
// Directed and random checks of gcd_stein_seq at WIDTH=8; out_cycles is
// checked as well when GCD_CYCLE_COUNT_EN is defined.
module tb_gcd_stein_seq;
  import gcd_pkg::*;

  localparam int WIDTH = 8;
  localparam int M     = WIDTH - 1;
  localparam int BOUND = cycle_bound(M);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gcd_stein_seq_if #(.WIDTH(WIDTH)) bus ();

  gcd_stein_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int a = x;
    int b = y;
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Entered at a negedge; returns at the negedge after the accept edge.
  task automatic start_pair(input logic [7:0] p, input logic [7:0] q);
    int guard = 0;
    bus.in_p     = p;
    bus.in_q     = q;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid is first seen high.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat <= BOUND + 4) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_pair(input string tag, input logic [7:0] p, input logic [7:0] q,
                          input int exp_gcd, input int exp_lat);
    int lat;
    start_pair(p, q);
    wait_result(lat);
    check({tag, "_gcd"}, 32'(bus.out_gcd), exp_gcd);
    check({tag, "_lat_bound"}, 32'(lat <= BOUND), 32'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
`ifdef GCD_CYCLE_COUNT_EN
    check({tag, "_cycles"}, 32'(bus.out_cycles), lat - 1);
`endif
    take_result();
  endtask

  initial begin
    int lat;
    logic [7:0] rp, rq;

    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_gcd", 32'(bus.out_gcd), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check("rst_out_cycles", 32'(bus.out_cycles), 32'd0);
`endif

    run_pair("g48_18", 8'd48, 8'd18, 6, -1);
    run_pair("g64_96", 8'd64, 8'd96, 32, -1);
    run_pair("g127_1", 8'd127, 8'd1, 1, -1);
    run_pair("g8c_0", 8'h8C, 8'd0, 12, 2);
    run_pair("g0_9", 8'd0, 8'd9, 9, 2);
    run_pair("g0_0", 8'd0, 8'd0, 0, 2);
    run_pair("gff_7f", 8'hFF, 8'h7F, 127, -1);
    run_pair("g100_75", 8'd100, 8'd75, 25, -1);

    // Result held under back-pressure; the bench keeps out_ready low.
    start_pair(8'd100, 8'd75);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_gcd", 32'(bus.out_gcd), 32'd25);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    take_result();
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // 48,18: one NORM shift, then REDUCE; reset lands inside REDUCE.
    start_pair(8'd48, 8'd18);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    run_pair("g35_21", 8'd35, 8'd21, 7, -1);

    for (int i = 0; i < 300; i++) begin
      rp = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      run_pair("rand", rp, rq, ref_gcd(int'(rp[6:0]), int'(rq[6:0])), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/gcd_stein_seq.md
# gcd_stein_seq

Parametrised, clocked binary (Stein) GCD engine: accepts a pair of WIDTH-bit sign-magnitude operands through a valid/ready handshake. It computes the GCD of their magnitudes iteratively, one reduction step per clock, and returns the result through a second valid/ready handshake. It replaces the single-shot, reset-triggered GCD unit in the arithmetic assignment datapath. It is the building block for multi-operand GCD/LCM units that need back-pressure and a bounded, synthesizable loop.

## Interface
- WIDTH, 8: operand width including sign bit. Magnitude width is M = WIDTH-1. Legal range is WIDTH ≥ 3.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (sampled on clk; asserted when 0)
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine can accept a pair; high only in IDLE
- in_p  input  WIDTH  operand P, sign-magnitude; bit WIDTH-1 is the sign and is ignored
- in_q  input  WIDTH  operand Q, same format
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_gcd  output  WIDTH  GCD, always non-negative; bit WIDTH-1 is always 0
- out_cycles  output  $clog2(5*M+4)  compute cycles used (present only with GCD_CYCLE_COUNT_EN)

## Operation
- **Registers:**
  - magnitudes a, b (M bits)
  - common-shift count k (ceil(log2(M+1)) bits)
  - state
- **States:**
  - IDLE
    - in_ready=1.
    - On in_valid: load a=in_p[M-1:0], b=in_q[M-1:0], k=0, then go to NORM.
  - NORM
    - If a==0 or b==0, go to DONE.
    - Else if a[0]==0 and b[0]==0: a>>=1, b>>=1, k+=1.
    - Else go to REDUCE.
  - REDUCE (exactly one action per cycle, in priority order)
    1. If a==0 or b==0, go to DONE.
    2. Else if a[0]==0, a>>=1.
    3. Else if b[0]==0, b>>=1.
    4. Else if a≥b, a=a-b.
    5. Else b=b-a.
  - DONE
    - Register out_gcd = {1'b0, (a|b) << k}. The shift cannot overflow M bits.
    - Assert out_valid and hold it with out_gcd stable until out_ready.
    - On out_valid && out_ready, go to IDLE.
- **Arithmetic:**
  - All datapath is unsigned M bits. Subtraction is always larger minus smaller, so no borrow is possible.
- **Boundaries:**
  - gcd(0,0)=0.
  - gcd(0,x)=gcd(x,0)=x.
  - Sign bits never affect the result. For example, in_p=8'h8C gives magnitude 12.
  - in_valid while not in IDLE is ignored (in_ready=0). The source must hold its data.
  - Reset in any state returns to IDLE next edge. The in-flight operation is discarded.

## Timing
- **Reset values:** in_ready=1 after the reset edge (state IDLE); out_valid=0; out_gcd=0; out_cycles=0.
- **Acceptance:** the pair is accepted on the edge where in_valid && in_ready.
- **NORM:** occupies ≤ M+1 cycles.
- **REDUCE:** occupies ≤ 4*M+1 cycles.
- **Total latency:** accept edge to out_valid rising is ≤ 5*M+3 cycles. The minimum is 2 cycles (a zero operand: NORM then DONE).
- **Handshake:** no new operand is accepted until the result handshake completes. in_ready returns high the cycle after out_valid && out_ready.
- **Stability:** out_gcd and out_cycles are stable while out_valid=1.

## Configuration
- GCD_CYCLE_COUNT_EN
  - Defined: out_cycles exists. It counts clock cycles spent in NORM and REDUCE for the current operation. It is registered into the output in DONE and cleared on accept.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- **Package gcd_pkg:**
  - state enum gcd_state_t {IDLE, NORM, REDUCE, DONE}
  - localparam function for the cycle bound 5*M+3
  - width helper for k and the counter
- **Sub-module gcd_step:**
  - Combinational, parametrised by M.
  - Inputs a, b. Outputs next a, next b, and a zero_flag.
  - Implements the REDUCE priority rule.
- The top holds the FSM, the registers, the handshake and the optional counter.

## Test plan
- **Basic result:** WIDTH=8, P=48, Q=18 → out_gcd=6, within 38 cycles of accept.
- **Common power-of-two factor:** P=64, Q=96 → out_gcd=32 (k=5). P=127, Q=1 → out_gcd=1.
- **Zero and sign cases:**
  - P=8'h8C, Q=0 → out_gcd=12.
  - P=0, Q=0 → out_gcd=0 with latency 2.
  - P=8'hFF, Q=8'h7F → out_gcd=127.
- **Back-pressure:**
  - Hold out_ready=0 for 10 cycles after out_valid → out_valid and out_gcd stay stable and in_ready stays 0.
  - Pulse out_ready → in_ready=1 next cycle.
- **Reset mid-REDUCE:** drive rst=0 for one edge → next cycle in_ready=1, out_valid=0. A following pair 35, 21 then yields 7.
- **Random sweep:** 10k random pairs at WIDTH=8 and WIDTH=16 against a reference model. Check latency ≤ 5*M+3. With GCD_CYCLE_COUNT_EN, check out_cycles equals the measured NORM+REDUCE cycles.
